divider_control_unit: RTL and testbench
=======================================

# divider_control_unit

FSM sequencer for the integer divider datapath: a shift-and-subtract (restoring) division controller. It drives load/shift/count enables for the iteration counter and the X, R and Y registers, plus the datapath mux selects. It sequences load, initial shift, N compare/subtract/shift iterations, a final R correction, and a done state. The counter value and the R<Y comparison are returned from the datapath.

## Interface
- No parameters; state code width is 4, counter width is 4.
- clk  in  1  system clock; all state changes occur on the rising edge.
- rst  in  1  asynchronous, active-low reset; forces state S0.
- go  in  1  start request, sampled in S0.
- r_lt_y  in  1  datapath compare: remainder R < divisor Y.
- count  in  4  iteration counter value from the datapath.
- ld, ud, ce  out  1 each  counter load, up/down (0 = down), count enable.
- ldx, slx, srx, cex  out  1 each  X register load, shift-left, shift-right, enable.
- ldr, slr, srr, cer  out  1 each  R register load, shift-left, shift-right, enable.
- s1, s2, s3  out  1 each  datapath mux selects.
- done  out  1  division complete.
- ld_y  out  1  Y register load.
- right_in_x  out  1  serial bit shifted into X LSB (the quotient bit).
- CS  out  4  current state code, 0–7.

## Operation
- Eight states, S0–S7, encoded 0–7 on CS. Any code 8–15 decodes as S0 (all outputs 0) and moves to S0 on the next edge.
- Listed outputs are 1; every unlisted output is 0.
- **S0 (idle)**: all outputs 0. go=1 → S1; otherwise stay in S0.
- **S1 (load)**: ld, ce, ldx, ldr, ld_y. Next state S2.
- **S2 (initial shift)**: ce, slx, slr, ld_y (counter counts down). Next state S3.
- **S3 (compare)** — Mealy on r_lt_y:
  - r_lt_y=1: ld_y only. Next state S5.
  - r_lt_y=0: ldr, s1, ld_y, right_in_x (R ← R−Y). Next state S4.
- **S4 (shift, quotient bit 1)**: ce, slx, slr, ld_y, right_in_x. count==0 → S6; otherwise S3.
- **S5 (shift, quotient bit 0)**: ce, slx, slr, s1, ld_y. count==0 → S6; otherwise S3.
- **S6 (correct R)**: srr, ld_y. Next state S7.
- **S7 (done)**: s2, s3, done, ld_y. Next state S0 unconditionally, so done is a one-cycle pulse.
- ud is 0 in every state.
- go is ignored outside S0. A new go is accepted in S0 on the cycle after S7.

## Timing
- Single always-block state register, asynchronous clear on rst=0. While reset is active: CS=0 and all outputs 0.
- Outputs are combinational from state; S3 outputs additionally depend on r_lt_y in the same cycle.
- count and r_lt_y are sampled at the rising edge for the S3/S4/S5 transitions.
- Latency for counter value N (loaded in S1): S0→S1→S2, then N passes through S3 plus S4 or S5, then S6, then S7.
  - Example: count reaches 0 after the 4th shift → done is asserted 12 edges after go is sampled in S0.
- Reset asserted mid-operation returns immediately to S0; no partial outputs remain.

## Structure
- Shared package `divider_pkg`: state typedef/localparams S0..S7 (4-bit) and the counter width.
- Natural split into two parts:
  - next-state logic plus state register;
  - a combinational output decoder sub-module `cu_output_decode` (inputs: state, r_lt_y; outputs: the 17 control signals).

## Test plan
- Reset: assert rst=0 in any state → CS=0 and all outputs 0, held until release.
- Idle: go=0 for 5 cycles → CS stays 0. go=1 → CS 1, then 2; check the S1 and S2 output sets exactly.
- Subtract path: count=4, r_lt_y=0 in S3 → outputs ldr, s1, ld_y, right_in_x; next CS=4 with ce, slx, slr, ld_y, right_in_x.
- Full run: count driven 4→3→2→1, decremented after each S3; r_lt_y=1 at the last S3 → CS 4 then 5, count=0 → CS 6 (srr, ld_y) → CS 7 (s2, s3, done, ld_y) → CS 0.
- Loop-back: in S4 or S5 with count=2 → next CS=3. In S4 or S5 with count=0 → next CS=6.
- Illegal state: force CS=9 → all outputs 0 and CS=0 after one edge.

Source files
------------

// File: rtl/divider_pkg.sv
// ============================================================================
// Module      : divider_pkg
// Description : Shared state encoding and widths for the divider controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package divider_pkg;

    localparam int C_STATE_W = 4;
    localparam int C_CNT_W   = 4;

    typedef enum logic [C_STATE_W-1:0] {
        S0 = 4'd0,
        S1 = 4'd1,
        S2 = 4'd2,
        S3 = 4'd3,
        S4 = 4'd4,
        S5 = 4'd5,
        S6 = 4'd6,
        S7 = 4'd7
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cu_output_decode.sv
// ============================================================================
// Module      : cu_output_decode
// Description : Combinational control-signal decoder for the divider FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cu_output_decode
    import divider_pkg::*;
(
    input  logic [C_STATE_W-1:0] state,
    input  logic                 r_lt_y,
    output logic                 ld,
    output logic                 ud,
    output logic                 ce,
    output logic                 ldx,
    output logic                 slx,
    output logic                 srx,
    output logic                 cex,
    output logic                 ldr,
    output logic                 slr,
    output logic                 srr,
    output logic                 cer,
    output logic                 s1,
    output logic                 s2,
    output logic                 s3,
    output logic                 done,
    output logic                 ld_y,
    output logic                 right_in_x
);

    always_comb begin
        ld         = 1'b0;
        ud         = 1'b0;
        ce         = 1'b0;
        ldx        = 1'b0;
        slx        = 1'b0;
        srx        = 1'b0;
        cex        = 1'b0;
        ldr        = 1'b0;
        slr        = 1'b0;
        srr        = 1'b0;
        cer        = 1'b0;
        s1         = 1'b0;
        s2         = 1'b0;
        s3         = 1'b0;
        done       = 1'b0;
        ld_y       = 1'b0;
        right_in_x = 1'b0;
        case (state)
            S1: begin
                ld   = 1'b1;
                ce   = 1'b1;
                ldx  = 1'b1;
                ldr  = 1'b1;
                ld_y = 1'b1;
            end
            S2: begin
                ce   = 1'b1;
                slx  = 1'b1;
                slr  = 1'b1;
                ld_y = 1'b1;
            end
            S3: begin
                // R >= Y: load R with R-Y and record a 1 quotient bit
                ld_y = 1'b1;
                if (!r_lt_y) begin
                    ldr        = 1'b1;
                    s1         = 1'b1;
                    right_in_x = 1'b1;
                end
            end
            S4: begin
                ce         = 1'b1;
                slx        = 1'b1;
                slr        = 1'b1;
                ld_y       = 1'b1;
                right_in_x = 1'b1;
            end
            S5: begin
                ce   = 1'b1;
                slx  = 1'b1;
                slr  = 1'b1;
                s1   = 1'b1;
                ld_y = 1'b1;
            end
            S6: begin
                srr  = 1'b1;
                ld_y = 1'b1;
            end
            S7: begin
                s2   = 1'b1;
                s3   = 1'b1;
                done = 1'b1;
                ld_y = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/divider_control_unit.sv
// ============================================================================
// Module      : divider_control_unit
// Description : Restoring shift-and-subtract divider sequencer (S0..S7).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_control_unit
    import divider_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 r_lt_y,
    input  logic [C_CNT_W-1:0]   count,
    output logic                 ld,
    output logic                 ud,
    output logic                 ce,
    output logic                 ldx,
    output logic                 slx,
    output logic                 srx,
    output logic                 cex,
    output logic                 ldr,
    output logic                 slr,
    output logic                 srr,
    output logic                 cer,
    output logic                 s1,
    output logic                 s2,
    output logic                 s3,
    output logic                 done,
    output logic                 ld_y,
    output logic                 right_in_x,
    output logic [C_STATE_W-1:0] CS
);

    logic [C_STATE_W-1:0] r_state;
    state_t               w_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S0;
        end else begin
            r_state <= w_next;
        end
    end

    // Codes 8..15 fall through to default and recover to idle
    always_comb begin
        w_next = S0;
        case (r_state)
            S0:      w_next = go ? S1 : S0;
            S1:      w_next = S2;
            S2:      w_next = S3;
            S3:      w_next = r_lt_y ? S5 : S4;
            S4, S5:  w_next = (count == '0) ? S6 : S3;
            S6:      w_next = S7;
            S7:      w_next = S0;
            default: w_next = S0;
        endcase
    end

    assign CS = r_state;

    cu_output_decode u_decode (
        .state      (r_state),
        .r_lt_y     (r_lt_y),
        .ld         (ld),
        .ud         (ud),
        .ce         (ce),
        .ldx        (ldx),
        .slx        (slx),
        .srx        (srx),
        .cex        (cex),
        .ldr        (ldr),
        .slr        (slr),
        .srr        (srr),
        .cer        (cer),
        .s1         (s1),
        .s2         (s2),
        .s3         (s3),
        .done       (done),
        .ld_y       (ld_y),
        .right_in_x (right_in_x)
    );

endmodule

`default_nettype wire

// File: tb/tb_divider_control_unit.sv
// ============================================================================
// Module      : tb_divider_control_unit
// Description : Directed self-checking bench for divider_control_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divider_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic       r_lt_y;
    logic [3:0] count;
    logic       ld, ud, ce, ldx, slx, srx, cex, ldr, slr, srr, cer;
    logic       s1, s2, s3, done, ld_y, right_in_x;
    logic [3:0] cs;
    logic [16:0] w_outs;

    int n_checks = 0;
    int n_fail   = 0;

    // Bit order: ld ud ce ldx slx srx cex ldr slr srr cer s1 s2 s3 done ld_y right_in_x
    localparam logic [16:0] C_E_IDLE = 17'b0_0000_0000_0000_0000;
    localparam logic [16:0] C_E_S1   = 17'b1_0110_0010_0000_0010;
    localparam logic [16:0] C_E_S2   = 17'b0_0101_0001_0000_0010;
    localparam logic [16:0] C_E_S3L  = 17'b0_0000_0000_0000_0010;
    localparam logic [16:0] C_E_S3S  = 17'b0_0000_0010_0010_0011;
    localparam logic [16:0] C_E_S4   = 17'b0_0101_0001_0000_0011;
    localparam logic [16:0] C_E_S5   = 17'b0_0101_0001_0010_0010;
    localparam logic [16:0] C_E_S6   = 17'b0_0000_0000_1000_0010;
    localparam logic [16:0] C_E_S7   = 17'b0_0000_0000_0001_1110;

    assign w_outs = {ld, ud, ce, ldx, slx, srx, cex, ldr, slr, srr, cer,
                     s1, s2, s3, done, ld_y, right_in_x};

    divider_control_unit dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .r_lt_y     (r_lt_y),
        .count      (count),
        .ld         (ld),
        .ud         (ud),
        .ce         (ce),
        .ldx        (ldx),
        .slx        (slx),
        .srx        (srx),
        .cex        (cex),
        .ldr        (ldr),
        .slr        (slr),
        .srr        (srr),
        .cer        (cer),
        .s1         (s1),
        .s2         (s2),
        .s3         (s3),
        .done       (done),
        .ld_y       (ld_y),
        .right_in_x (right_in_x),
        .CS         (cs)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        go  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; go = 1'b1; r_lt_y = 1'b0; count = 4'd4;
        #1 rst = 1'b0;
        #2;
        n_checks++;
        if (cs !== 4'd0 || w_outs !== C_E_IDLE) begin
            n_fail++;
            $display("FAIL reset_entry: cs=%0d outs=%b, required cs=0 outs=%b", cs, w_outs, C_E_IDLE);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (cs !== 4'd0 || w_outs !== C_E_IDLE) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: cs=%0d outs=%b, required cs=0 outs=0", i, cs, w_outs);
            end
        end
        @(negedge clk);
        go  = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); go = 1'b0; #1;
            n_checks++;
            if (cs !== 4'd0 || w_outs !== C_E_IDLE) begin
                n_fail++;
                $display("FAIL idle[%0d]: cs=%0d outs=%b, required cs=0 outs=0", i, cs, w_outs);
            end
        end
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0; #1;
        n_checks++;
        if (cs !== 4'd1 || w_outs !== C_E_S1) begin
            n_fail++;
            $display("FAIL idle_to_s1: cs=%0d outs=%b, required cs=1 outs=%b", cs, w_outs, C_E_S1);
        end
        @(negedge clk); #1;
        n_checks++;
        if (cs !== 4'd2 || w_outs !== C_E_S2) begin
            n_fail++;
            $display("FAIL s1_to_s2: cs=%0d outs=%b, required cs=2 outs=%b", cs, w_outs, C_E_S2);
        end
        do_reset();
    endtask

    // pat[i] is r_lt_y in the i-th S3; count runs 4,3,2,1 and reaches 0 in the last shift
    task automatic test_full_run(input logic [3:0] pat, input bit hold_go);
        int e;
        int cnt;
        logic [3:0] exp_cs;
        logic [16:0] exp_o;
        do_reset();
        @(negedge clk);
        go = 1'b1; cnt = 4; count = 4'd4; r_lt_y = 1'b0; e = 0;
        @(negedge clk); e++;
        if (!hold_go) go = 1'b0;
        #1;
        n_checks++;
        if (cs !== 4'd1 || w_outs !== C_E_S1) begin
            n_fail++;
            $display("FAIL run_s1: cs=%0d outs=%b, required cs=1 outs=%b", cs, w_outs, C_E_S1);
        end
        @(negedge clk); e++; #1;
        n_checks++;
        if (cs !== 4'd2 || w_outs !== C_E_S2) begin
            n_fail++;
            $display("FAIL run_s2: cs=%0d outs=%b, required cs=2 outs=%b", cs, w_outs, C_E_S2);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); e++;
            count = 4'(cnt); r_lt_y = pat[i]; #1;
            exp_o = pat[i] ? C_E_S3L : C_E_S3S;
            n_checks++;
            if (cs !== 4'd3 || w_outs !== exp_o) begin
                n_fail++;
                $display("FAIL run_s3[%0d]: cs=%0d outs=%b, required cs=3 outs=%b", i, cs, w_outs, exp_o);
            end
            @(negedge clk); e++;
            cnt--; count = 4'(cnt); r_lt_y = 1'($urandom); #1;
            exp_cs = pat[i] ? 4'd5 : 4'd4;
            exp_o  = pat[i] ? C_E_S5 : C_E_S4;
            n_checks++;
            if (cs !== exp_cs || w_outs !== exp_o) begin
                n_fail++;
                $display("FAIL run_shift[%0d]: cs=%0d outs=%b, required cs=%0d outs=%b", i, cs, w_outs, exp_cs, exp_o);
            end
        end
        @(negedge clk); e++; #1;
        n_checks++;
        if (cs !== 4'd6 || w_outs !== C_E_S6) begin
            n_fail++;
            $display("FAIL run_s6: cs=%0d outs=%b, required cs=6 outs=%b", cs, w_outs, C_E_S6);
        end
        @(negedge clk); e++; #1;
        n_checks++;
        if (cs !== 4'd7 || w_outs !== C_E_S7 || e !== 12) begin
            n_fail++;
            $display("FAIL run_done: cs=%0d outs=%b edge=%0d, required cs=7 outs=%b edge=12", cs, w_outs, e, C_E_S7);
        end
        @(negedge clk); #1;
        n_checks++;
        if (cs !== 4'd0 || w_outs !== C_E_IDLE) begin
            n_fail++;
            $display("FAIL run_back_idle: cs=%0d outs=%b, required cs=0 outs=0", cs, w_outs);
        end
        if (hold_go) begin
            @(negedge clk); #1;
            n_checks++;
            if (cs !== 4'd1) begin
                n_fail++;
                $display("FAIL back_to_back_go: cs=%0d, required cs=1", cs);
            end
        end
        go = 1'b0;
    endtask

    task automatic test_midop_reset();
        do_reset();
        @(negedge clk); go = 1'b1; r_lt_y = 1'b0; count = 4'd4;
        @(negedge clk); go = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        n_checks++;
        if (cs !== 4'd3) begin
            n_fail++;
            $display("FAIL midop_reach_s3: cs=%0d, required cs=3", cs);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (cs !== 4'd0 || w_outs !== C_E_IDLE) begin
            n_fail++;
            $display("FAIL midop_reset: cs=%0d outs=%b, required cs=0 outs=0", cs, w_outs);
        end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_illegal();
        do_reset();
        @(negedge clk);
        go = 1'b0; r_lt_y = 1'b0; count = 4'd0;
        force dut.r_state = 4'd9;
        #1;
        n_checks++;
        if (cs !== 4'd9 || w_outs !== C_E_IDLE) begin
            n_fail++;
            $display("FAIL illegal_outs: cs=%0d outs=%b, required cs=9 outs=0", cs, w_outs);
        end
        release dut.r_state;
        @(negedge clk); #1;
        n_checks++;
        if (cs !== 4'd0 || w_outs !== C_E_IDLE) begin
            n_fail++;
            $display("FAIL illegal_recover: cs=%0d outs=%b, required cs=0 outs=0", cs, w_outs);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_full_run(4'b1010, 1'b0);
        test_full_run(4'b0111, 1'b1);
        test_midop_reset();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
